// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Writeback arbitration in front of the register file write port.
//            Single-cycle ALU results always take the port. Memory/multiply
//            results queue in a small FIFO and drain when the ALU is idle.
//            A pending scoreboard tracks registers whose memory result has
//            not yet been written, so decode can stall on them.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            alu_valid/wadd/data - ALU result, never stalled
//            mem_valid/ready/wadd/data - memory result handshake
//            issue_valid/wadd    - decode issued a memory/mul op
//            wadd/datain/wr      - registered register-file write port
//            pend                - outstanding memory writes, one bit per reg
//            fifo_count          - memory FIFO occupancy
// Option   : define WB_BYPASS_EN to let a memory result skip an empty FIFO
//            when the ALU is idle (one-cycle latency instead of two).
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DW    = 24,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [AW-1:0]             alu_wadd,
  input  logic [DW-1:0]             alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [AW-1:0]             mem_wadd,
  input  logic [DW-1:0]             mem_data,
  input  logic                      issue_valid,
  input  logic [AW-1:0]             issue_wadd,
  output logic [AW-1:0]             wadd,
  output logic [DW-1:0]             datain,
  output logic                      wr,
  output logic [(1<<AW)-1:0]        pend,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              NREG    = 1 << AW;
  localparam logic [PW:0]     C_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0]     C_ONE   = (PW+1)'(1);

  logic [AW-1:0]   r_fifo_wadd [DEPTH];
  logic [DW-1:0]   r_fifo_data [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW:0]     r_count;
  logic [AW-1:0]   r_wadd;
  logic [DW-1:0]   r_datain;
  logic            r_wr;
  logic [NREG-1:0] r_pend;

  logic            w_full;
  logic            w_empty;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_head_wadd;
  logic [DW-1:0]   w_head_data;
  logic [NREG-1:0] w_pend_nxt;
  logic [PW:0]     w_count_nxt;

  assign w_full      = (r_count == C_DEPTH);
  assign w_empty     = (r_count == '0);
  assign mem_ready   = !w_full;
  assign w_head_wadd = r_fifo_wadd[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

`ifdef WB_BYPASS_EN
  // An empty FIFO always has room, so mem_valid alone implies a handshake.
  assign w_bypass = !alu_valid && w_empty && mem_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = !alu_valid && !w_empty;
  assign w_push = mem_valid && mem_ready && !w_bypass;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_pop)       w_pend_nxt[w_head_wadd] = 1'b0;
    if (w_bypass)    w_pend_nxt[mem_wadd]    = 1'b0;
    // Applied last so that a new issue wins over a same-edge retirement.
    if (issue_valid) w_pend_nxt[issue_wadd]  = 1'b1;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wadd[r_wr_ptr] <= mem_wadd;
      r_fifo_data[r_wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_wr     <= 1'b0;
      r_wadd   <= '0;
      r_datain <= '0;
      r_pend   <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;

      if (alu_valid) begin
        r_wr     <= 1'b1;
        r_wadd   <= alu_wadd;
        r_datain <= alu_data;
      end else if (w_pop) begin
        r_wr     <= 1'b1;
        r_wadd   <= w_head_wadd;
        r_datain <= w_head_data;
      end else if (w_bypass) begin
        r_wr     <= 1'b1;
        r_wadd   <= mem_wadd;
        r_datain <= mem_data;
      end else begin
        r_wr     <= 1'b0;
      end
    end
  end

  assign wadd       = r_wadd;
  assign datain     = r_datain;
  assign wr         = r_wr;
  assign pend       = r_pend;
  assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter. Directed scenarios followed
//            by a randomized run, all compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  localparam int DW    = 24;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_wadd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_wadd;
  logic [DW-1:0] mem_data;
  logic          issue_valid;
  logic [AW-1:0] issue_wadd;
  logic [AW-1:0] wadd;
  logic [DW-1:0] datain;
  logic          wr;
  logic [31:0]   pend;
  logic [2:0]    fifo_count;

  // Reference model state
  ent_t          q[$];
  logic [31:0]   m_pend;
  logic          m_wr;
  logic [AW-1:0] m_wadd;
  logic [DW-1:0] m_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wadd(alu_wadd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wadd(mem_wadd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_wadd(issue_wadd),
    .wadd(wadd), .datain(datain), .wr(wr),
    .pend(pend), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;
  endtask

  // Advance the model by one clock from the currently driven inputs, then
  // clock the DUT and compare every output.
  task automatic step();
    ent_t e;
    bit   rdy;
    bit   byp;
    rdy = (q.size() != DEPTH);
    byp = 1'b0;
`ifdef WB_BYPASS_EN
    byp = !alu_valid && (q.size() == 0) && mem_valid;
`endif
    if (rst) begin
      q.delete();
      m_pend = '0; m_wr = 1'b0; m_wadd = '0; m_data = '0;
    end else begin
      if (alu_valid) begin
        m_wr = 1'b1; m_wadd = alu_wadd; m_data = alu_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_wr = 1'b1; m_wadd = e.a; m_data = e.d;
        m_pend[e.a] = 1'b0;
      end else if (byp) begin
        m_wr = 1'b1; m_wadd = mem_wadd; m_data = mem_data;
        m_pend[mem_wadd] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (mem_valid && rdy && !byp) begin
        e.a = mem_wadd; e.d = mem_data;
        q.push_back(e);
      end
      if (issue_valid) m_pend[issue_wadd] = 1'b1;
    end
    @(posedge clk); #1;
    chk("wr",         32'(wr),         32'(m_wr));
    chk("wadd",       32'(wadd),       32'(m_wadd));
    chk("datain",     32'(datain),     32'(m_data));
    chk("pend",       pend,            m_pend);
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("mem_ready",  32'(mem_ready),  32'(q.size() != DEPTH));
  endtask

  initial begin
    idle();
    alu_wadd = '0; alu_data = '0; mem_wadd = '0; mem_data = '0; issue_wadd = '0;
    m_pend = '0; m_wr = 1'b0; m_wadd = '0; m_data = '0;
    #1;

    // Reset with ALU traffic present: nothing must be written.
    rst = 1'b1; alu_valid = 1'b1; alu_wadd = 5'd7; alu_data = 24'h777777;
    step();
    chk("reset_wr", 32'(wr), 32'd0);
    step();
    chk("reset_pend", pend, 32'd0);
    chk("reset_ready", 32'(mem_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("post_reset_wadd", 32'(wadd), 32'd7);

    // ALU only
    idle(); alu_valid = 1'b1; alu_wadd = 5'd3; alu_data = 24'h00ABCD;
    step();
    chk("alu_wr", 32'(wr), 32'd1);
    chk("alu_data", 32'(datain), 32'h00ABCD);
    idle();
    step();
    chk("alu_idle_wr", 32'(wr), 32'd0);

    // Memory queuing
    idle(); issue_valid = 1'b1; issue_wadd = 5'd9;
    step();
    chk("pend9_set", 32'(pend[9]), 32'd1);
    idle(); mem_valid = 1'b1; mem_wadd = 5'd9; mem_data = 24'h123456;
    step();
    idle();
    step();
`ifndef WB_BYPASS_EN
    chk("mem_wadd", 32'(wadd), 32'd9);
    chk("mem_data", 32'(datain), 32'h123456);
`endif
    chk("pend9_clr", 32'(pend[9]), 32'd0);
    step();

    // Contention: five ALU cycles, four memory arrivals
    for (int i = 0; i < 5; i++) begin
      idle();
      alu_valid = 1'b1; alu_wadd = 5'(20 + i); alu_data = 24'($urandom);
      if (i < 4) begin
        mem_valid = 1'b1; mem_wadd = 5'(i); mem_data = 24'($urandom);
      end
      step();
    end
    chk("cont_full", 32'(fifo_count), 32'd4);
    chk("cont_ready", 32'(mem_ready), 32'd0);
    idle();
    for (int i = 0; i < 5; i++) step();

    // Set/clear collision on reg 12
    idle(); alu_valid = 1'b1; alu_wadd = 5'd1; alu_data = 24'h1;
    mem_valid = 1'b1; mem_wadd = 5'd12; mem_data = 24'hC0FFEE;
    step();
    idle(); issue_valid = 1'b1; issue_wadd = 5'd12;
    step();
    chk("coll_wadd", 32'(wadd), 32'd12);
    chk("coll_pend12", 32'(pend[12]), 32'd1);
    idle();
    step();

`ifdef WB_BYPASS_EN
    idle(); mem_valid = 1'b1; mem_wadd = 5'd2; mem_data = 24'h000055;
    step();
    chk("byp_wadd", 32'(wadd), 32'd2);
    chk("byp_count", 32'(fifo_count), 32'd0);
    idle();
    step();
`endif

    // Randomized traffic, with occasional mid-operation resets
    for (int i = 0; i < 800; i++) begin
      idle();
      rst         = ($urandom_range(0, 63) == 0);
      alu_wadd    = 5'($urandom);
      alu_data    = 24'($urandom);
      alu_valid   = ($urandom_range(0, 9) < 4) && !m_pend[alu_wadd];
      mem_valid   = ($urandom_range(0, 9) < 6);
      mem_wadd    = 5'($urandom);
      mem_data    = 24'($urandom);
      issue_valid = ($urandom_range(0, 9) < 4);
      issue_wadd  = 5'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
